// File: rtl/upconv_nch.sv
// ---------------------------------------------------------------------------
// upconv_nch
// N-channel interleaved-IQ upconverter. Each channel multiplies its I/Q
// interleaved baseband stream by two LO lanes, sums each lane's product with
// the previous one (so every sum holds one I and one Q term), rounds, shifts
// and saturates, producing two DAC samples per clock (dac1 for the first
// half-cycle, dac2 for the second).
//
// Ports
//   clk       in   1        system clock
//   rst_n     in   1        synchronous reset, active low
//   enable    in   1        1 = outputs active, 0 = outputs forced to 0
//   clear     in   1        pulse, clears sat_flag and flag_err
//   iq_flag   in   1        1 = I sample, 0 = Q sample; must alternate
//   iq_data   in   NCH*DW   signed baseband samples, channel k at [k*DW +: DW]
//   lo1       in   NCH*LW   signed LO lane 1 per channel
//   lo2       in   NCH*LW   signed LO lane 2 per channel
//   dac1      out  NCH*OW   signed first-half-cycle DAC sample per channel
//   dac2      out  NCH*OW   signed second-half-cycle DAC sample per channel
//   sat_flag  out  NCH      sticky saturation flag per channel
//   flag_err  out  1        sticky iq_flag alternation error
//
// Pipeline: products -> pair sums -> rounded/saturated DAC (3 clocks).
// ---------------------------------------------------------------------------
module upconv_nch #(
    parameter int NCH   = 2,
    parameter int DW    = 18,
    parameter int LW    = 18,
    parameter int OW    = 16,
    parameter int SHIFT = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              iq_flag,
    input  logic [NCH*DW-1:0] iq_data,
    input  logic [NCH*LW-1:0] lo1,
    input  logic [NCH*LW-1:0] lo2,
    output logic [NCH*OW-1:0] dac1,
    output logic [NCH*OW-1:0] dac2,
    output logic [NCH-1:0]    sat_flag,
    output logic              flag_err
);

    localparam int PW = DW + LW;   // full product width
    localparam int SW = PW + 1;    // pair-sum width
    localparam int RW = SW + 1;    // headroom for the rounding constant

    // Full-precision signed product.
    function automatic logic signed [PW-1:0] f_mul(
        input logic signed [DW-1:0] a,
        input logic signed [LW-1:0] b
    );
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        ax = PW'(a);
        bx = PW'(b);
        return ax * bx;
    endfunction

    // Sum of current and previous product without truncation.
    function automatic logic signed [SW-1:0] f_pair(
        input logic signed [PW-1:0] a,
        input logic signed [PW-1:0] b
    );
        logic signed [SW-1:0] ax;
        logic signed [SW-1:0] bx;
        ax = SW'(a);
        bx = SW'(b);
        return ax + bx;
    endfunction

    // Round half up, arithmetic shift, saturate. MSB of result = clipped.
    function automatic logic [OW:0] f_round_sat(input logic signed [SW-1:0] s);
        logic signed [RW-1:0] rnd;
        logic signed [RW-1:0] v;
        logic signed [RW-1:0] vmax;
        logic signed [RW-1:0] vmin;
        logic        [OW:0]   res;
        rnd = '0;
        rnd[SHIFT-1] = 1'b1;
        v    = (RW'(s) + rnd) >>> SHIFT;
        vmax = RW'($signed({1'b0, {(OW-1){1'b1}}}));
        vmin = RW'($signed({1'b1, {(OW-1){1'b0}}}));
        if (v > vmax) begin
            res = {1'b1, vmax[OW-1:0]};
        end else if (v < vmin) begin
            res = {1'b1, vmin[OW-1:0]};
        end else begin
            res = {1'b0, v[OW-1:0]};
        end
        return res;
    endfunction

    logic signed [PW-1:0] r_p1  [NCH];
    logic signed [PW-1:0] r_p2  [NCH];
    logic signed [PW-1:0] r_p1d [NCH];
    logic signed [PW-1:0] r_p2d [NCH];
    logic signed [SW-1:0] r_s1  [NCH];
    logic signed [SW-1:0] r_s2  [NCH];
    logic signed [OW-1:0] r_dac1 [NCH];
    logic signed [OW-1:0] r_dac2 [NCH];
    logic [NCH-1:0]       r_sat;
    logic                 r_flag_err;
    logic                 r_prev_flag;
    logic                 r_flag_vld;

    logic signed [PW-1:0] w_p1 [NCH];
    logic signed [PW-1:0] w_p2 [NCH];
    logic [OW:0]          w_q1 [NCH];
    logic [OW:0]          w_q2 [NCH];
    logic                 w_err_set;
    logic                 w_err_next;
    logic                 w_mute;

    // Products, rounding and the next state of the error/mute controls.
    always_comb begin
        w_err_set  = r_flag_vld && (iq_flag == r_prev_flag);
        // A new error wins over a same-cycle clear.
        w_err_next = w_err_set | (r_flag_err & ~clear);
        // Mute uses the next error state so dac goes to 0 on the edge flag_err rises.
        w_mute     = ~enable | w_err_next;
        for (int k = 0; k < NCH; k++) begin
            w_p1[k] = f_mul(iq_data[k*DW +: DW], lo1[k*LW +: LW]);
            w_p2[k] = f_mul(iq_data[k*DW +: DW], lo2[k*LW +: LW]);
            w_q1[k] = f_round_sat(r_s1[k]);
            w_q2[k] = f_round_sat(r_s2[k]);
        end
    end

    // Pipeline registers, sticky flags and iq_flag history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                r_p1[k]   <= '0;
                r_p2[k]   <= '0;
                r_p1d[k]  <= '0;
                r_p2d[k]  <= '0;
                r_s1[k]   <= '0;
                r_s2[k]   <= '0;
                r_dac1[k] <= '0;
                r_dac2[k] <= '0;
            end
            r_sat       <= '0;
            r_flag_err  <= 1'b0;
            r_prev_flag <= 1'b0;
            r_flag_vld  <= 1'b0;
        end else begin
            r_prev_flag <= iq_flag;
            r_flag_vld  <= 1'b1;
            r_flag_err  <= w_err_next;
            for (int k = 0; k < NCH; k++) begin
                r_p1[k]  <= w_p1[k];
                r_p2[k]  <= w_p2[k];
                r_p1d[k] <= r_p1[k];
                r_p2d[k] <= r_p2[k];
                r_s1[k]  <= f_pair(r_p1[k], r_p1d[k]);
                r_s2[k]  <= f_pair(r_p2[k], r_p2d[k]);
                if (w_mute) begin
                    r_dac1[k] <= '0;
                    r_dac2[k] <= '0;
                end else begin
                    r_dac1[k] <= w_q1[k][OW-1:0];
                    r_dac2[k] <= w_q2[k][OW-1:0];
                end
                // Clipping is a data-path property; it is flagged even when muted.
                r_sat[k] <= w_q1[k][OW] | w_q2[k][OW] | (r_sat[k] & ~clear);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_out
            assign dac1[g*OW +: OW] = r_dac1[g];
            assign dac2[g*OW +: OW] = r_dac2[g];
        end
    endgenerate

    assign sat_flag = r_sat;
    assign flag_err = r_flag_err;

endmodule

// File: tb/tb_upconv_nch.sv
module tb_upconv_nch;

    localparam int NCH   = 2;
    localparam int DW    = 18;
    localparam int LW    = 18;
    localparam int OW    = 16;
    localparam int SHIFT = 19;

    localparam int L = 131070;
    localparam int N = -131070;
    localparam int M = 131071;
    localparam int Z = -131072;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              enable;
    logic              clear;
    logic              iq_flag;
    logic [NCH*DW-1:0] iq_data;
    logic [NCH*LW-1:0] lo1;
    logic [NCH*LW-1:0] lo2;
    logic [NCH*OW-1:0] dac1;
    logic [NCH*OW-1:0] dac2;
    logic [NCH-1:0]    sat_flag;
    logic              flag_err;

    upconv_nch #(.NCH(NCH), .DW(DW), .LW(LW), .OW(OW), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .iq_flag(iq_flag), .iq_data(iq_data), .lo1(lo1), .lo2(lo2),
        .dac1(dac1), .dac2(dac2), .sat_flag(sat_flag), .flag_err(flag_err)
    );

    // fm: 0 = toggle iq_flag, 1 = hold previous value, 2 = force 0
    typedef struct {
        bit r; bit en; bit clr; int fm;
        int iq0; int iq1; int la; int lb2;
        int ea; int eb1; int eb2; int es; int ee;
    } vec_t;

    typedef struct {
        int d1a; int d2a; int d1b; int d2b; int es; int ee; int idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    bit   cur_flag = 1'b0;

    task automatic add(input bit r, input bit en, input bit clr, input int fm,
                       input int iq0, input int iq1, input int la, input int lb2,
                       input int ea, input int eb1, input int eb2, input int es, input int ee);
        vec_t v;
        v.r = r; v.en = en; v.clr = clr; v.fm = fm;
        v.iq0 = iq0; v.iq1 = iq1; v.la = la; v.lb2 = lb2;
        v.ea = ea; v.eb1 = eb1; v.eb2 = eb2; v.es = es; v.ee = ee;
        vecs.push_back(v);
    endtask

    // ch0: lo1 = lo2 = la; ch1: lo1 = la, lo2 = lb2
    task automatic drive(input bit r, input bit en, input bit clr, input int fm,
                         input int iq0, input int iq1, input int la, input int lb2);
        rst_n  = r;
        enable = en;
        clear  = clr;
        case (fm)
            0:       cur_flag = ~cur_flag;
            1:       cur_flag = cur_flag;
            default: cur_flag = 1'b0;
        endcase
        iq_flag = cur_flag;
        iq_data = {DW'(iq1), DW'(iq0)};
        lo1     = {LW'(la), LW'(la)};
        lo2     = {LW'(lb2), LW'(la)};
    endtask

    task automatic check_out(input exp_t e);
        int a1a, a2a, a1b, a2b, as, ae;
        a1a = int'($signed(dac1[OW-1:0]));
        a2a = int'($signed(dac2[OW-1:0]));
        a1b = int'($signed(dac1[2*OW-1:OW]));
        a2b = int'($signed(dac2[2*OW-1:OW]));
        as  = int'(sat_flag);
        ae  = int'(flag_err);
        checks++;
        if (a1a != e.d1a || a2a != e.d2a || a1b != e.d1b || a2b != e.d2b ||
            as != e.es || ae != e.ee) begin
            failures++;
            $display("FAIL step%0d: got dac1_0=%0d dac2_0=%0d dac1_1=%0d dac2_1=%0d sat=%0d err=%0d expected %0d %0d %0d %0d sat=%0d err=%0d",
                     e.idx, a1a, a2a, a1b, a2b, as, ae, e.d1a, e.d2a, e.d1b, e.d2b, e.es, e.ee);
        end
    endtask

    // Reference: round half up, arithmetic shift, clamp to OW bits.
    function automatic int ref_round(input longint s);
        longint r;
        longint lim;
        lim = longint'(1) <<< (OW - 1);
        r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > lim - 1) r = lim - 1;
        if (r < -lim)    r = -lim;
        return int'(r);
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        exp_t   e;
        longint pv0, pv1b, pv2b;
        longint p0, p1b, p2b;
        int     iq0, iq1, la, lb2;

        drive(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);

        // Reset held with nonzero inputs
        for (int i = 0; i < 3; i++) add(0,1,0,0, 5000,5000, L,L, 0,0,0, 0,0);
        // Impulse on ch0
        add(1,1,0,0, 4000,0, L,L, 0,0,0, 0,0);
        add(1,1,0,0, 0,0,    L,L, 0,0,0, 0,0);
        add(1,1,0,0, 0,0,    L,L, 1000,0,0, 0,0);
        add(1,1,0,0, 0,0,    L,L, 1000,0,0, 0,0);
        add(1,1,0,0, 0,0,    L,L, 0,0,0, 0,0);
        add(1,1,0,0, 0,0,    L,L, 0,0,0, 0,0);
        // Steady, ch1 lane 2 uses negated LO
        add(1,1,0,0, 4000,4000, L,N, 0,0,0, 0,0);
        add(1,1,0,0, 4000,4000, L,N, 0,0,0, 0,0);
        add(1,1,0,0, 4000,4000, L,N, 1000,1000,-1000, 0,0);
        add(1,1,0,0, 4000,4000, L,N, 2000,2000,-2000, 0,0);
        add(1,1,0,0, 4000,4000, L,N, 2000,2000,-2000, 0,0);
        add(1,1,0,0, 4000,4000, L,N, 2000,2000,-2000, 0,0);
        // enable low for two edges, then immediately valid again
        add(1,0,0,0, 4000,4000, L,N, 0,0,0, 0,0);
        add(1,0,0,0, 4000,4000, L,N, 0,0,0, 0,0);
        add(1,1,0,0, 4000,4000, L,N, 2000,2000,-2000, 0,0);
        // Flush
        add(1,1,0,0, 0,0, L,N, 2000,2000,-2000, 0,0);
        add(1,1,0,0, 0,0, L,N, 2000,2000,-2000, 0,0);
        add(1,1,0,0, 0,0, L,N, 1000,1000,-1000, 0,0);
        add(1,1,0,0, 0,0, L,N, 0,0,0, 0,0);
        // Saturation, sticky flag, clear with set winning, then clear
        add(1,1,0,0, M,M, M,M, 0,0,0, 0,0);
        add(1,1,0,0, M,M, M,M, 0,0,0, 0,0);
        add(1,1,0,0, Z,Z, M,M, 32767,32767,32767, 3,0);
        add(1,1,0,0, Z,Z, M,M, 32767,32767,32767, 3,0);
        add(1,1,0,0, 0,0, M,M, 0,0,0, 3,0);
        add(1,1,1,0, 0,0, M,M, -32768,-32768,-32768, 3,0);
        add(1,1,1,0, 0,0, M,M, -32768,-32768,-32768, 0,0);
        add(1,1,0,0, 0,0, M,M, 0,0,0, 0,0);
        // Alternation error: mute until clear
        add(1,1,0,1, 4000,4000, L,L, 0,0,0, 0,1);
        add(1,1,0,0, 4000,4000, L,L, 0,0,0, 0,1);
        add(1,1,1,0, 4000,4000, L,L, 1000,1000,1000, 0,0);
        add(1,1,0,0, 4000,4000, L,L, 2000,2000,2000, 0,0);
        // Reset mid-stream; first post-reset flag equals the reset value of history
        add(0,1,0,0, 4000,4000, L,L, 0,0,0, 0,0);
        add(1,1,0,2, 4000,4000, L,L, 0,0,0, 0,0);
        add(1,1,0,0, 4000,4000, L,L, 0,0,0, 0,0);
        add(1,1,0,0, 4000,4000, L,L, 1000,1000,1000, 0,0);
        add(1,1,0,0, 4000,4000, L,L, 2000,2000,2000, 0,0);
        add(1,1,0,0, 4000,4000, L,L, 2000,2000,2000, 0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].en, vecs[i].clr, vecs[i].fm,
                  vecs[i].iq0, vecs[i].iq1, vecs[i].la, vecs[i].lb2);
            e.d1a = vecs[i].ea;  e.d2a = vecs[i].ea;
            e.d1b = vecs[i].eb1; e.d2b = vecs[i].eb2;
            e.es  = vecs[i].es;  e.ee  = vecs[i].ee; e.idx = i;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            check_out(sbq.pop_front());
        end

        // Random data: model predictions queued at drive time, checked 3 edges later.
        e.d1a = 2000; e.d2a = 2000; e.d1b = 2000; e.d2b = 2000; e.es = 0; e.ee = 0;
        e.idx = 1000; sbq.push_back(e);
        e.idx = 1001; sbq.push_back(e);
        pv0  = longint'(4000) * longint'(L);
        pv1b = pv0;
        pv2b = pv0;
        for (int n = 0; n < 40; n++) begin
            iq0 = int'($urandom_range(131070, 0)) - 65535;
            iq1 = int'($urandom_range(131070, 0)) - 65535;
            la  = int'($urandom_range(131070, 0)) - 65535;
            lb2 = int'($urandom_range(131070, 0)) - 65535;
            drive(1'b1, 1'b1, 1'b0, 0, iq0, iq1, la, lb2);
            p0  = longint'(iq0) * longint'(la);
            p1b = longint'(iq1) * longint'(la);
            p2b = longint'(iq1) * longint'(lb2);
            e.d1a = ref_round(p0 + pv0);
            e.d2a = e.d1a;
            e.d1b = ref_round(p1b + pv1b);
            e.d2b = ref_round(p2b + pv2b);
            e.es = 0; e.ee = 0; e.idx = 1002 + n;
            sbq.push_back(e);
            pv0 = p0; pv1b = p1b; pv2b = p2b;
            @(posedge clk);
            #1;
            check_out(sbq.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
